// File: rtl/stack_level_ctrl.sv
// stack_level_ctrl -- game controller for a stacking game.
// A block (row_pos) moves back and forth across an 8-bit row on each
// tick. A button press locks it onto the previous row (stack_row). Only the
// overlapping bits survive and become the next block. An empty overlap loses
// the game. Locking at MAX_LEVEL wins it.
//
// Ports:
//   clock     : system clock, rising edge
//   reset     : synchronous, active-high
//   btn       : raw asynchronous push-button, active-high
//   tick      : one-clock movement strobe
//   level     : current level, 1..MAX_LEVEL
//   row_pos   : bitmask of the moving block
//   stack_row : bitmask of the last locked row
//   game_over : high while LOST
//   game_won  : high while WON
module stack_level_ctrl #(
  parameter logic [3:0] MAX_LEVEL = 4'd8,
  parameter logic [7:0] INIT_ROW  = 8'b00000111
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn,
  input  logic       tick,
  output logic [3:0] level,
  output logic [7:0] row_pos,
  output logic [7:0] stack_row,
  output logic       game_over,
  output logic       game_won
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PLAY = 2'd1;
  localparam logic [1:0] S_WON  = 2'd2;
  localparam logic [1:0] S_LOST = 2'd3;

  // LEFT moves toward bit 7
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  logic [1:0] r_state;
  logic       r_dir;
  logic       r_sync1, r_sync2, r_btn_prev;
  logic [3:0] r_level;
  logic [7:0] r_row;
  logic [7:0] r_stack;
  logic       r_over, r_won;

  logic       w_press;
  logic [7:0] w_ov;

  // The press pulse is taken combinationally from the flops. btn is sampled
  // on edge N. The FSM therefore reacts on edge N+2.
  assign w_press = r_sync2 & ~r_btn_prev;
  assign w_ov    = r_row & r_stack;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_btn_prev <= 1'b0;
    end else begin
      r_sync1    <= btn;
      r_sync2    <= r_sync1;
      r_btn_prev <= r_sync2;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_dir   <= DIR_LEFT;
      r_level <= 4'd1;
      r_row   <= INIT_ROW;
      r_stack <= 8'hFF;
      r_over  <= 1'b0;
      r_won   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_press) begin
            r_state <= S_PLAY;
            r_dir   <= DIR_LEFT;
          end
        end
        S_PLAY: begin
          // A press wins over a tick in the same cycle. The lock then uses the
          // pre-tick position.
          if (w_press) begin
            if (w_ov == 8'h00) begin
              r_state <= S_LOST;
              r_over  <= 1'b1;
            end else begin
              r_stack <= w_ov;
              r_row   <= w_ov;
              if (r_level < MAX_LEVEL) begin
                r_level <= r_level + 4'd1;
                r_dir   <= DIR_LEFT;
              end else begin
                r_state <= S_WON;
                r_won   <= 1'b1;
              end
            end
          end else if (tick) begin
            // At an edge the block reverses and steps back in the same tick.
            // It never stalls and never shifts a bit out.
            if (r_dir == DIR_LEFT) begin
              if (r_row[7]) begin
                r_dir <= DIR_RIGHT;
                r_row <= r_row >> 1;
              end else begin
                r_row <= r_row << 1;
              end
            end else begin
              if (r_row[0]) begin
                r_dir <= DIR_LEFT;
                r_row <= r_row << 1;
              end else begin
                r_row <= r_row >> 1;
              end
            end
          end
        end
        S_WON, S_LOST: begin
          if (w_press) begin
            r_state <= S_IDLE;
            r_dir   <= DIR_LEFT;
            r_level <= 4'd1;
            r_row   <= INIT_ROW;
            r_stack <= 8'hFF;
            r_over  <= 1'b0;
            r_won   <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_over  <= 1'b0;
          r_won   <= 1'b0;
        end
      endcase
    end
  end

  assign level     = r_level;
  assign row_pos   = r_row;
  assign stack_row = r_stack;
  assign game_over = r_over;
  assign game_won  = r_won;

endmodule

// File: tb/tb_stack_level_ctrl.sv
// Bench for stack_level_ctrl. It uses a vector table, several hand-written
// corner sequences and randomized play. Every cycle is also compared with a
// reference model. The model stores the block as (lowest bit index, width)
// and direction.
module tb_stack_level_ctrl;

  logic       clock, reset, btn, tick;
  logic [3:0] level;
  logic [7:0] row_pos, stack_row;
  logic       game_over, game_won;

  stack_level_ctrl #(.MAX_LEVEL(4'd8), .INIT_ROW(8'b00000111)) dut (
    .clock(clock), .reset(reset), .btn(btn), .tick(tick),
    .level(level), .row_pos(row_pos), .stack_row(stack_row),
    .game_over(game_over), .game_won(game_won)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_cmp = 0;
  int n_bad = 0;

  // reference model
  localparam int MS_IDLE = 0, MS_PLAY = 1, MS_WON = 2, MS_LOST = 3;
  localparam int M_MAX = 8, INIT_LO = 0, INIT_W = 3;
  int       m_st, m_lvl, m_lo, m_w;
  bit       m_left;
  bit [7:0] m_stack;
  bit       s1, s2, s3;   // btn sampled 1, 2 and 3 edges ago

  function automatic bit [7:0] mask(input int lo, input int w);
    bit [7:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) m[i] = (i >= lo) && (i < lo + w);
    return m;
  endfunction

  function automatic int lowest(input bit [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic model_edge(input bit r, input bit b, input bit t);
    bit       press;
    bit [7:0] ov;
    if (r) begin
      m_st = MS_IDLE; m_lvl = 1; m_lo = INIT_LO; m_w = INIT_W;
      m_left = 1; m_stack = 8'hFF; s1 = 0; s2 = 0; s3 = 0;
      return;
    end
    press = s2 && !s3;
    s3 = s2; s2 = s1; s1 = b;
    case (m_st)
      MS_IDLE: if (press) begin m_st = MS_PLAY; m_left = 1; end
      MS_PLAY: begin
        if (press) begin
          ov = mask(m_lo, m_w) & m_stack;
          if (ov == 0) m_st = MS_LOST;
          else begin
            m_stack = ov; m_lo = lowest(ov); m_w = $countones(ov);
            if (m_lvl < M_MAX) begin m_lvl++; m_left = 1; end
            else m_st = MS_WON;
          end
        end else if (t) begin
          if (m_left) begin
            if (m_lo + m_w - 1 == 7) begin m_left = 0; m_lo--; end
            else m_lo++;
          end else begin
            if (m_lo == 0) begin m_left = 1; m_lo++; end
            else m_lo--;
          end
        end
      end
      default: if (press) begin
        m_st = MS_IDLE; m_lvl = 1; m_lo = INIT_LO; m_w = INIT_W;
        m_left = 1; m_stack = 8'hFF;
      end
    endcase
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp_model();
    check("model.level", 32'(level), 32'(m_lvl));
    check("model.row_pos", 32'(row_pos), 32'(mask(m_lo, m_w)));
    check("model.stack_row", 32'(stack_row), 32'(m_stack));
    check("model.game_over", 32'(game_over), 32'(m_st == MS_LOST));
    check("model.game_won", 32'(game_won), 32'(m_st == MS_WON));
  endtask

  task automatic step(input bit r, input bit b, input bit t);
    reset = r; btn = b; tick = t;
    @(posedge clock);
    model_edge(r, b, t);
    #1;
    cmp_model();
  endtask

  // Drives a one-cycle button pulse and returns after the edge where it acts.
  task automatic press_act(input bit t);
    step(0, 1, 0);
    step(0, 0, 0);
    step(0, 0, t);
  endtask

  task automatic expect_out(input string name, input logic [3:0] l, input logic [7:0] r,
                            input logic [7:0] s, input logic o, input logic w);
    check({name, ".level"}, 32'(level), 32'(l));
    check({name, ".row_pos"}, 32'(row_pos), 32'(r));
    check({name, ".stack_row"}, 32'(stack_row), 32'(s));
    check({name, ".game_over"}, 32'(game_over), 32'(o));
    check({name, ".game_won"}, 32'(game_won), 32'(w));
  endtask

  typedef struct {
    bit         rst, b, t;
    logic [3:0] lvl;
    logic [7:0] row, stk;
    logic       ovr, won;
  } vec_t;

  vec_t tbl[21];

  initial begin
    bit bcur;
    reset = 1'b0; btn = 1'b0; tick = 1'b0;
    m_st = MS_IDLE; m_lvl = 1; m_lo = INIT_LO; m_w = INIT_W;
    m_left = 1; m_stack = 8'hFF; s1 = 0; s2 = 0; s3 = 0;

    // rst, btn, tick -> outputs after that edge
    tbl[0]  = '{1, 0, 0, 4'd1, 8'h07, 8'hFF, 0, 0};
    tbl[1]  = '{0, 0, 1, 4'd1, 8'h07, 8'hFF, 0, 0};  // IDLE ignores tick
    tbl[2]  = '{0, 1, 0, 4'd1, 8'h07, 8'hFF, 0, 0};
    tbl[3]  = '{0, 0, 0, 4'd1, 8'h07, 8'hFF, 0, 0};
    tbl[4]  = '{0, 0, 0, 4'd1, 8'h07, 8'hFF, 0, 0};  // press -> PLAY
    tbl[5]  = '{0, 0, 1, 4'd1, 8'h0E, 8'hFF, 0, 0};
    tbl[6]  = '{0, 0, 1, 4'd1, 8'h1C, 8'hFF, 0, 0};
    tbl[7]  = '{0, 0, 1, 4'd1, 8'h38, 8'hFF, 0, 0};
    tbl[8]  = '{0, 0, 1, 4'd1, 8'h70, 8'hFF, 0, 0};
    tbl[9]  = '{0, 0, 1, 4'd1, 8'hE0, 8'hFF, 0, 0};
    tbl[10] = '{0, 0, 1, 4'd1, 8'h70, 8'hFF, 0, 0};  // bounce
    tbl[11] = '{0, 0, 1, 4'd1, 8'h38, 8'hFF, 0, 0};
    tbl[12] = '{0, 0, 1, 4'd1, 8'h1C, 8'hFF, 0, 0};
    tbl[13] = '{0, 1, 0, 4'd1, 8'h1C, 8'hFF, 0, 0};
    tbl[14] = '{0, 0, 0, 4'd1, 8'h1C, 8'hFF, 0, 0};
    tbl[15] = '{0, 0, 0, 4'd2, 8'h1C, 8'h1C, 0, 0};  // lock
    tbl[16] = '{0, 0, 1, 4'd2, 8'h38, 8'h1C, 0, 0};
    tbl[17] = '{0, 1, 0, 4'd2, 8'h38, 8'h1C, 0, 0};
    tbl[18] = '{0, 0, 0, 4'd2, 8'h38, 8'h1C, 0, 0};
    tbl[19] = '{0, 0, 0, 4'd3, 8'h18, 8'h18, 0, 0};  // partial lock
    tbl[20] = '{0, 0, 1, 4'd3, 8'h30, 8'h18, 0, 0};

    #2;
    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].b, tbl[i].t);
      expect_out($sformatf("vec%0d", i), tbl[i].lvl, tbl[i].row, tbl[i].stk,
                 tbl[i].ovr, tbl[i].won);
    end

    // 20 ticks in IDLE change nothing
    step(1, 0, 0);
    repeat (20) step(0, 0, 1);
    expect_out("idle_ticks", 4'd1, 8'h07, 8'hFF, 0, 0);

    // no-overlap lock: stack 07 against block E0
    step(1, 0, 0);
    press_act(0);
    press_act(0);
    expect_out("lock07", 4'd2, 8'h07, 8'h07, 0, 0);
    repeat (5) step(0, 0, 1);
    press_act(0);
    expect_out("lost", 4'd2, 8'hE0, 8'h07, 1, 0);
    press_act(0);
    expect_out("lost_restart", 4'd1, 8'h07, 8'hFF, 0, 0);

    // eight aligned locks win; WON ignores ticks
    step(1, 0, 0);
    press_act(0);
    repeat (7) press_act(0);
    expect_out("level8", 4'd8, 8'h07, 8'h07, 0, 0);
    press_act(0);
    expect_out("won", 4'd8, 8'h07, 8'h07, 0, 1);
    repeat (10) step(0, 0, 1);
    expect_out("won_hold", 4'd8, 8'h07, 8'h07, 0, 1);
    press_act(0);
    expect_out("won_restart", 4'd1, 8'h07, 8'hFF, 0, 0);

    // press coincident with tick locks the pre-tick position
    step(1, 0, 0);
    press_act(0);
    step(0, 0, 1);
    step(0, 0, 1);
    press_act(1);
    expect_out("press_tick", 4'd2, 8'h1C, 8'h1C, 0, 0);

    // reset mid-game at level 5 with btn and tick also high
    step(1, 0, 0);
    press_act(0);
    repeat (4) press_act(0);
    check("lvl5", 32'(level), 32'd5);
    step(1, 1, 1);
    expect_out("mid_reset", 4'd1, 8'h07, 8'hFF, 0, 0);

    // btn held through reset release gives one press
    step(0, 1, 0);
    step(0, 1, 0);
    step(0, 1, 0);
    step(0, 1, 1);
    expect_out("held_at_reset", 4'd1, 8'h0E, 8'hFF, 0, 0);
    repeat (3) step(0, 0, 0);

    // btn held 50 cycles locks exactly once
    repeat (50) step(0, 1, 0);
    expect_out("held50", 4'd2, 8'h0E, 8'h0E, 0, 0);
    repeat (3) step(0, 0, 0);

    // randomized play against the model
    bcur = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) bcur = ~bcur;
      step($urandom_range(0, 299) == 0, bcur, 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stack_level_ctrl.md
STACK_LEVEL_CTRL -- requirements
Module: stack_level_ctrl

Interface
REQ-001 SHALL have parameter MAX_LEVEL, default 4'd8, meaning highest level; a successful lock at this level wins the game.
REQ-002 SHALL have parameter INIT_ROW, default 8'b00000111, meaning the starting moving-block bitmask, which must be contiguous and non-zero.
REQ-003 SHALL have port clock, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port btn, input, 1 bit: raw asynchronous player push-button, active-high.
REQ-006 SHALL have port tick, input, 1 bit: one-clock movement strobe from the clock divider.
REQ-007 SHALL have port level, output, 4 bits: current level (1..MAX_LEVEL); it drives external_segment.level.
REQ-008 SHALL have port row_pos, output, 8 bits: bitmask of the currently moving block.
REQ-009 SHALL have port stack_row, output, 8 bits: bitmask of the last locked row.
REQ-010 SHALL have port game_over, output, 1 bit: high while in state LOST.
REQ-011 SHALL have port game_won, output, 1 bit: high while in state WON.
REQ-012 All outputs SHALL be registered.

Function
REQ-013 The block SHALL pass btn through a 2-flop synchronizer, then a rising-edge detector producing a one-clock press pulse.
- A press pulse SHALL affect outputs on the 3rd rising clock edge after btn is first sampled high.
- Holding btn SHALL yield exactly one press pulse.
REQ-014 The block SHALL implement an FSM with states IDLE, PLAY, WON, LOST; the state encoding is internal.
REQ-015 In IDLE:
- row_pos and stack_row SHALL hold their values and tick SHALL be ignored.
- On press: go to PLAY with dir=LEFT; level, row_pos and stack_row are unchanged.
REQ-016 In PLAY, on tick with no press (dir=LEFT means toward bit 7):
- dir=LEFT and row_pos[7]=0: row_pos <= row_pos<<1.
- dir=LEFT and row_pos[7]=1: dir <= RIGHT, row_pos <= row_pos>>1.
- dir=RIGHT and row_pos[0]=0: row_pos <= row_pos>>1.
- dir=RIGHT and row_pos[0]=1: dir <= LEFT, row_pos <= row_pos<<1.
- A single-bit block SHALL bounce without stalling; shifting SHALL never lose bits.
REQ-017 In PLAY, on press, compute ov = row_pos & stack_row; if ov == 0, go to LOST and leave level, row_pos and stack_row unchanged.
REQ-018 In PLAY, on press with ov != 0 and level < MAX_LEVEL:
- stack_row <= ov, row_pos <= ov, level <= level+1, dir <= LEFT.
- Stay in PLAY.
REQ-019 In PLAY, on press with ov != 0 and level == MAX_LEVEL:
- stack_row <= ov, row_pos <= ov.
- level holds at MAX_LEVEL and the FSM goes to WON.
REQ-020 When press and tick coincide, press SHALL take priority and tick SHALL be discarded that cycle.
REQ-021 level SHALL never exceed MAX_LEVEL and SHALL never be 0; no wrap-around.
REQ-022 In WON or LOST:
- tick SHALL be ignored.
- On press: go to IDLE with level=1, row_pos=INIT_ROW, stack_row=8'hFF, dir=LEFT.
REQ-023 game_over SHALL equal (state==LOST) and game_won SHALL equal (state==WON), both registered with the state.

Reset
REQ-024 When reset is high at a rising edge, the block SHALL set state=IDLE, level=4'd1, row_pos=INIT_ROW, stack_row=8'hFF, dir=LEFT, game_over=0, game_won=0, and clear the synchronizer and edge-detector flops to 0.
REQ-025 Reset SHALL override press and tick in the same cycle, from any state including mid-game.
REQ-026 A btn already held high when reset deasserts SHALL produce one press pulse after synchronization.

Verification
REQ-027 Reset, then 20 ticks with no press -> level=1, row_pos=8'b00000111, stack_row=8'hFF, game_over=0, game_won=0.
REQ-028 Press to PLAY, then 5 ticks -> row_pos sequence 0E,1C,38,70,E0; 6th tick -> 70, with dir reversed.
REQ-029 In PLAY:
- Step 1: at row_pos=8'h1C with stack_row=FF, press -> stack_row=1C, level=2.
- Step 2: after 1 tick (row_pos=38), press -> stack_row=18, row_pos=18, level=3.
REQ-030 Lock a row with no overlap (stack_row=03, row_pos=E0) -> game_over=1 and level unchanged; next press -> IDLE, level=1, row_pos=07, stack_row=FF.
REQ-031 With MAX_LEVEL=8, perform 8 aligned locks -> game_won=1 and level=8 held; further ticks -> no change.
REQ-032 Stress boundary timing:
- Press coincident with tick -> lock uses the pre-tick row_pos.
- Reset asserted mid-PLAY at level 5 -> all reset values on the next edge.
- btn held 50 cycles -> exactly one lock.
